tcam_match_penc: RTL

- Downstream stage of the 7x64 TCAM block.
- Consumes the 64-bit per-row match vectors (one per 7-bit query chunk) read out of the TCAM over successive cycles.
- ANDs all chunks of one search into a final match vector, then priority-encodes it into a row address plus hit / multi-hit flags.
- Presents the result to the search controller with a valid/ready handshake.

---
 rtl/tcam_pkg.sv | 24 ++
 rtl/tcam_priority_encoder.sv | 34 +++
 rtl/tcam_match_penc.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tcam_pkg.sv
// ============================================================================
// Module      : tcam_pkg
// Description : Shared types for the TCAM match-vector post-processing stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tcam_pkg;

  localparam int TCAM_ROWS    = 64;
  localparam int TCAM_CHUNK_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ENCODE = 2'd2,
    DONE   = 2'd3
  } penc_state_e;

  typedef logic [TCAM_ROWS-1:0] match_vec_t;

endpackage : tcam_pkg

`default_nettype wire

// File: rtl/tcam_priority_encoder.sv
// ============================================================================
// Module      : tcam_priority_encoder
// Description : Combinational lowest-index priority encoder with any/multi.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcam_priority_encoder #(
  parameter int NUM_ROWS = 64,
  parameter int ADDR_W   = $clog2(NUM_ROWS)
) (
  input  logic [NUM_ROWS-1:0] i_vec,
  output logic [ADDR_W-1:0]   o_idx,
  output logic                o_any,
  output logic                o_multi
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    o_idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = ADDR_W'(i);
      end
    end
  end

  assign o_any   = |i_vec;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign o_multi = |(i_vec & (i_vec - 1'b1));

endmodule : tcam_priority_encoder

`default_nettype wire

// File: rtl/tcam_match_penc.sv
// ============================================================================
// Module      : tcam_match_penc
// Description : ANDs per-chunk TCAM match vectors, priority-encodes the result
//               and hands it to the search controller over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcam_match_penc
  import tcam_pkg::*;
#(
  parameter int NUM_ROWS   = TCAM_ROWS,
  parameter int NUM_CHUNKS = 4,
  parameter int ADDR_W     = $clog2(NUM_ROWS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                chunk_valid_i,
  input  logic [NUM_ROWS-1:0] match_i,
  output logic                busy_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                hit_o,
  output logic                multi_hit_o,
  output logic [ADDR_W-1:0]   match_addr_o,
  output logic [NUM_ROWS-1:0] match_vec_o
);

  localparam int               C_CNT_W      = $clog2(NUM_CHUNKS + 1);
  localparam logic [C_CNT_W-1:0] C_LAST_CHUNK = C_CNT_W'(NUM_CHUNKS - 1);

  penc_state_e           r_state;
  logic [NUM_ROWS-1:0]   r_acc;
  logic [C_CNT_W-1:0]    r_cnt;
  logic                  r_busy;
  logic                  r_valid;
  logic                  r_hit;
  logic                  r_multi;
  logic [ADDR_W-1:0]     r_addr;
  logic [NUM_ROWS-1:0]   r_vec;

  logic [ADDR_W-1:0]     w_idx;
  logic                  w_any;
  logic                  w_multi;

  tcam_priority_encoder #(
    .NUM_ROWS (NUM_ROWS),
    .ADDR_W   (ADDR_W)
  ) u_penc (
    .i_vec   (r_acc),
    .o_idx   (w_idx),
    .o_any   (w_any),
    .o_multi (w_multi)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_acc   <= '1;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_hit   <= 1'b0;
      r_multi <= 1'b0;
      r_addr  <= '0;
      r_vec   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_acc   <= '1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ACCUM;
          end
        end

        ACCUM: begin
          if (chunk_valid_i) begin
            r_acc <= r_acc & match_i;
            // The counter parks at zero on the final chunk so it never
            // reaches NUM_CHUNKS.
            if (r_cnt == C_LAST_CHUNK) begin
              r_cnt   <= '0;
              r_state <= ENCODE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        ENCODE: begin
          r_hit   <= w_any;
          r_multi <= w_multi;
          r_addr  <= w_idx;
          r_vec   <= r_acc;
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
          r_state <= DONE;
        end

        DONE: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            // A start coinciding with the handshake skips IDLE entirely.
            if (start_i) begin
              r_acc   <= '1;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= ACCUM;
            end else begin
              r_state <= IDLE;
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o       = r_busy;
  assign valid_o      = r_valid;
  assign hit_o        = r_hit;
  assign multi_hit_o  = r_multi;
  assign match_addr_o = r_addr;
  assign match_vec_o  = r_vec;

endmodule : tcam_match_penc

`default_nettype wire
